// File: rtl/instr_fetch.sv
// Instruction fetch stage for the 6502 core: reads the reset vector, then fetches
// opcode plus 0-2 operand bytes and hands complete instructions to decode.
module instr_fetch #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        bus_grant,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [15:0] instr_pc,
  output logic [1:0]  instr_len,
  output logic [15:0] fetch_pc
);

  typedef enum logic [2:0] {VEC_LO, VEC_HI, OPC, OPLO, OPHI, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        capture_reg, capture_next;
  logic [15:0] pc_reg;
  logic        valid_reg;
  logic [7:0]  opcode_reg;
  logic [15:0] operand_reg;
  logic [15:0] instr_pc_reg;
  logic [1:0]  len_reg;
  logic [1:0]  len_dec;
  logic [3:0]  lo_nib, hi_nib;

  assign lo_nib = mem_rdata[3:0];
  assign hi_nib = mem_rdata[7:4];

  // Length decode from the byte on the bus; only consumed during the OPC capture.
  always_comb begin
    len_dec = 2'd2;
    if (lo_nib == 4'h8 || lo_nib == 4'hA || lo_nib == 4'h3 || lo_nib == 4'h7 ||
        lo_nib == 4'hB || mem_rdata == 8'h00 || mem_rdata == 8'h40 || mem_rdata == 8'h60)
      len_dec = 2'd1;
    else if (lo_nib >= 4'hC || mem_rdata == 8'h20 || (lo_nib == 4'h9 && hi_nib[0]))
      len_dec = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= VEC_LO;
      capture_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      capture_reg <= capture_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    capture_next = capture_reg;
    if (redirect) begin
      state_next   = OPC;
      capture_next = 1'b0;
    end else if (state_reg == HOLD) begin
      if (valid_reg && instr_ready) state_next = OPC;
    end else if (!capture_reg) begin
      if (bus_grant) capture_next = 1'b1;
    end else begin
      capture_next = 1'b0;
      case (state_reg)
        VEC_LO:  state_next = VEC_HI;
        VEC_HI:  state_next = OPC;
        OPC:     state_next = (len_dec == 2'd1) ? HOLD : OPLO;
        OPLO:    state_next = (len_reg == 2'd3) ? OPHI : HOLD;
        OPHI:    state_next = HOLD;
        default: state_next = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= 16'h0000;
      valid_reg    <= 1'b0;
      opcode_reg   <= 8'h00;
      operand_reg  <= 16'h0000;
      instr_pc_reg <= 16'h0000;
      len_reg      <= 2'd0;
    end else begin
      valid_reg <= (state_next == HOLD);
      if (redirect) begin
        pc_reg <= redirect_pc;
      end else if (capture_reg) begin
        case (state_reg)
          VEC_LO: pc_reg[7:0]  <= mem_rdata;
          VEC_HI: pc_reg[15:8] <= mem_rdata;
          OPC: begin
            opcode_reg   <= mem_rdata;
            instr_pc_reg <= pc_reg;
            operand_reg  <= 16'h0000;
            len_reg      <= len_dec;
            pc_reg       <= pc_reg + 16'd1;
          end
          OPLO: begin
            operand_reg[7:0] <= mem_rdata;
            pc_reg           <= pc_reg + 16'd1;
          end
          OPHI: begin
            operand_reg[15:8] <= mem_rdata;
            pc_reg            <= pc_reg + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (state_reg)
      VEC_LO:  mem_addr = RESET_VEC;
      VEC_HI:  mem_addr = RESET_VEC + 16'd1;
      default: mem_addr = pc_reg;
    endcase
  end

  // Read strobe is forced low while reset is held.
  assign mem_rd      = rst_n & bus_grant & ~capture_reg & (state_reg != HOLD);
  assign instr_valid = valid_reg;
  assign opcode      = opcode_reg;
  assign operand     = operand_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_len   = len_reg;
  assign fetch_pc    = pc_reg;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the 6502 core; sits directly upstream of the decode stage.
- After reset it reads the reset vector, then fetches the opcode and its 0–2 operand bytes from memory. It determines instruction length from the opcode byte.
- It presents one complete instruction (opcode, operand, pc, length) to decode over a valid/ready handshake.
- Execute can redirect it (jumps, branches, interrupts) and can borrow the memory bus.

Parameters:
- RESET_VEC, 16'hFFFC, address of the reset vector low byte; the high byte is at RESET_VEC+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  16  byte address (addr_t) for the read.
- mem_rd  out  1  read strobe, qualified by bus_grant.
- mem_rdata  in  8  read data (data_t), valid the cycle after mem_rd.
- bus_grant  in  1  fetch owns the bus this cycle.
- redirect  in  1  abort the current fetch and restart at redirect_pc.
- redirect_pc  in  16  new fetch address.
- instr_valid  out  1  instruction bundle valid.
- instr_ready  in  1  decode accepts the bundle.
- opcode  out  8  opcode byte.
- operand  out  16  {hi,lo}; unused bytes are zero.
- instr_pc  out  16  address of the opcode byte.
- instr_len  out  2  1, 2 or 3.
- fetch_pc  out  16  next address to fetch (debug/display).

Behaviour:
- Memory model: each byte takes an ISSUE cycle followed by a CAPTURE cycle.
  - ISSUE: mem_rd = bus_grant, mem_addr = target. The cycle only completes when bus_grant=1; otherwise it repeats.
  - CAPTURE: mem_rdata is latched unconditionally.
- States: VEC_LO, VEC_HI, OPC, OPLO, OPHI, HOLD. Each state except HOLD contains one ISSUE/CAPTURE pair.
- Reset (async):
  - state=VEC_LO, phase=ISSUE.
  - fetch_pc=0, instr_valid=0, opcode=0, operand=0, instr_pc=0, instr_len=0.
  - mem_rd=0 while rst_n=0; mem_addr=RESET_VEC.
- VEC_LO: read RESET_VEC into pc[7:0], then VEC_HI.
- VEC_HI: read RESET_VEC+1 into pc[15:8], then OPC.
- OPC:
  - Read at pc; instr_pc<=pc; pc<=pc+1; operand<=0.
  - Compute length from the captured byte b (low nibble L, high nibble H):
    - 1 byte: L ∈ {8,A,3,7,B}, or b ∈ {00,40,60}.
    - 3 byte: L ∈ {C,D,E,F}, or b=20, or (L=9 and H odd).
    - 2 byte: all others.
  - Next state: len=1 → HOLD; otherwise OPLO.
- OPLO: read at pc into operand[7:0]; pc<=pc+1. Next: len=3 → OPHI, else HOLD.
- OPHI: read at pc into operand[15:8]; pc<=pc+1; then HOLD.
- HOLD:
  - instr_valid=1; outputs stable until the handshake.
  - On instr_valid & instr_ready: instr_valid<=0, next state OPC. The next opcode ISSUE happens in the following cycle.
- Outputs are registered. instr_valid first asserts the cycle after the final CAPTURE.
- Latency: with bus_grant held at 1, a len-n instruction has instr_valid high 2n cycles after OPC ISSUE begins.
- PC arithmetic is 16-bit and wraps: FFFF+1=0000. Operand fetch also wraps (opcode at FFFF reads its operand at 0000).
- redirect=1 (any state, any phase):
  - Next cycle: state=OPC/ISSUE, pc=redirect_pc, instr_valid=0.
  - A pending CAPTURE is discarded.
  - If valid&ready occurs in the same cycle, the transfer counts and fetch still restarts at redirect_pc.
  - redirect during VEC_LO/VEC_HI also wins and aborts the vector fetch.
- bus_grant=0 during ISSUE: mem_rd=0, state and pc unchanged, no CAPTURE. bus_grant is ignored in CAPTURE and HOLD.
- fetch_pc always shows the internal pc.

Test Plan:
- Reset vector: mem[FFFC]=00, mem[FFFD]=80, bus_grant=1.
  - rst_n release → mem_addr=FFFC (cycle 1), FFFD (cycle 3), 8000 (cycle 5).
  - fetch_pc=8001 after OPC CAPTURE.
- Lengths: mem[8000..]=EA, A9 42, AD 34 12, instr_ready=1.
  - Bundles: {EA,0000,8000,1}, {A9,0042,8001,2}, {AD,1234,8003,3}.
  - instr_valid pulses 2/4/6 cycles after each OPC ISSUE.
- Backpressure: instr_ready=0 for 5 cycles while holding {AD,1234}.
  - Outputs stable, no mem_rd.
  - One cycle after ready=1, mem_addr=8006.
- Bus steal: bus_grant=0 for 3 cycles during OPLO ISSUE.
  - mem_rd=0 for those 3 cycles, pc unchanged.
  - Bundle delivered 3 cycles later with correct operand.
- Redirect: redirect=1 with redirect_pc=C000 during OPHI CAPTURE.
  - No bundle emitted; next mem_addr=C000.
  - Also repeat with redirect coincident with valid&ready: transfer counted, next mem_addr=C000.
- Wrap: pc=FFFF holding 4C 00 10.
  - Operand bytes read at 0000 and 0001; bundle {4C,1000,FFFF,3}; fetch_pc=0002.
